instr_encoder_q: RTL and testbench
==================================

// Module: instr_encoder_q
// PURPOSE
//  Encodes field-level RV32I requests (R, LOAD, STORE, BRANCH, OP-IMM) into 32-bit instruction words.
//  Produces exactly the opcodes the core control decoder consumes.
//  Buffers the words in a small FIFO for the debug/boot instruction-injection path into fetch.
//  valid/ready handshake on both sides; producer is the test/debug host, consumer is the fetch mux.
// PARAMETERS
//  DEPTH   4   FIFO entries, power of two, >=2
//  CNT_W   3   count width = log2(DEPTH)+1
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  flush       in   1      sync clear of FIFO contents (same effect as rst on the FIFO only)
//  in_valid    in   1      request valid
//  in_ready    out  1      request accepted when in_valid & in_ready
//  in_fmt      in   3      0=R 1=LOAD 2=STORE 3=BRANCH 4=OPIMM, 5..7 illegal
//  in_rd       in   5      rd
//  in_rs1      in   5      rs1
//  in_rs2      in   5      rs2
//  in_funct3   in   3      funct3
//  in_funct7   in   7      funct7 (R only)
//  in_imm      in   13     signed imm; I/S use [11:0], B uses [12:1]
//  out_valid   out  1      head word valid
//  out_ready   in   1      consumer pops when out_valid & out_ready
//  out_instr   out  32     head instruction word
//  count       out  CNT_W  entries held
//  err_illegal out  1      one-cycle pulse: illegal fmt dropped
//  err_range   out  1      one-cycle pulse: imm out of range dropped (macro only)
// BEHAVIOUR
//  Reset/flush: FIFO empty; out_valid=0, count=0, out_instr=0, err_*=0; in_ready=1 after reset.
//  in_ready = (count != DEPTH), purely from registered state; no pop-to-push bypass when full.
//  Encoding is combinational on the accept cycle; word is written to the FIFO at that edge.
//  Latency: word visible on out_instr/out_valid the cycle after accept when the FIFO was empty.
//  R:    {f7, rs2, rs1, f3, rd, 7'b0110011}
//  LOAD: {imm[11:0], rs1, f3, rd, 7'b0000011}
//  OPIMM:{imm[11:0], rs1, f3, rd, 7'b0010011}; shifts carry funct7 in imm[11:5]
//  STORE:{imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011}
//  BRANCH:{imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011}
//  Unused fields are ignored.
//  Illegal fmt: request is accepted (handshake completes) but not enqueued; err_illegal=1 next cycle.
//  Simultaneous push and pop: count unchanged, both occur.
//  Pointers wrap modulo DEPTH.
//  out_instr holds its value while out_valid=0; it is don't-care to the consumer.
//  flush has priority over a same-cycle push/pop; both are discarded.
//  rst mid-stream discards all entries; err pulses are cleared.
// CONFIGURATION
//  ENC_RANGE_CHECK_EN defined: the following requests are accepted, dropped, and pulse err_range next cycle:
//   - I/S requests with imm[12] != imm[11];
//   - B requests with imm[0] != 0.
//  ENC_RANGE_CHECK_EN undefined: imm is silently truncated, imm[0] is ignored for B, err_range tied 0.
//  If fmt is illegal, err_illegal takes precedence and err_range stays 0.
// STRUCTURE
//  rv_pkg: opcode localparams (OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM) and fmt codes.
//  rv_pkg is shared with the control decoder.
//  One sub-module: sync_fifo (DEPTH, width 32, push/pop/flush, count).
//  Encoder mux and error logic stay in this module.
// TESTING
//  OPIMM rd=1 rs1=0 f3=0 imm=5 -> out_instr 0x00500093 one cycle after accept.
//  R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> 0x002081B3.
//  LOAD rd=5 rs1=2 f3=2 imm=8 -> 0x00812283.
//  STORE rs1=2 rs2=5 f3=2 imm=12 -> 0x00512623.
//  BRANCH rs1=1 rs2=2 f3=0 imm=-8 -> 0xFE208CE3.
//  out_ready=0, push DEPTH words -> in_ready=0 and count=DEPTH.
//  Then pop one while pushing -> push refused that cycle and accepted next; FIFO order preserved.
//  fmt=6 -> err_illegal pulse, count unchanged.
//  With macro: BRANCH imm=3 -> err_range pulse, nothing enqueued.
//  Fill 3, assert flush with push -> count=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes, encoder format codes and field packers.
// Shared between the instruction encoder and the core control decoder.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_LOAD   = 3'd1,
        FMT_STORE  = 3'd2,
        FMT_BRANCH = 3'd3,
        FMT_OPIMM  = 3'd4
    } fmt_e;

    function automatic logic [31:0] enc_r(
        input logic [6:0] f7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] f3,
        input logic [4:0] rd
    );
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [6:0]  op
    );
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(
        input logic [11:0] imm,
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [2:0]  f3
    );
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    // B-type offsets are even, so bit 0 never reaches the word.
    function automatic logic [31:0] enc_b(
        input logic [12:1] imm,
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [2:0]  f3
    );
        return {imm[12], imm[10:5], rs2, rs1, f3,
                imm[4:1], imm[11], OP_BRANCH};
    endfunction

endpackage

// File: rtl/instr_encoder_q_if.sv
// instr_encoder_q_if: request and instruction-word handshake bundle.
// master = debug/boot host and fetch mux side, slave = encoder queue.
interface instr_encoder_q_if #(
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [12:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [CNT_W-1:0] count;
    logic             err_illegal;
    logic             err_range;

    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, count,
        input  err_illegal, err_range
    );

    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, count,
        output err_illegal, err_range
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, flush and sticky head word.
// dout keeps the last popped word while empty; reset/flush zero it.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hold;
    logic             w_push;
    logic             w_pop;
    logic             w_clr;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_clr  = rst | flush;
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = empty ? r_hold : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/instr_encoder_q.sv
// instr_encoder_q: RV32I field-to-word encoder feeding a small injection FIFO.
// Define ENC_RANGE_CHECK_EN to drop and flag out-of-range immediates.
module instr_encoder_q
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    instr_encoder_q_if.slave bus
);
    fmt_e             w_fmt;
    logic [31:0]      w_word;
    logic             w_legal;
    logic             w_i_bad;
    logic             w_b_bad;
    logic             w_range_bad;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [31:0]      w_dout;
    logic             r_err_illegal;
    logic             r_err_range;

    assign w_fmt = fmt_e'(bus.in_fmt);

`ifdef ENC_RANGE_CHECK_EN
    assign w_i_bad = bus.in_imm[12] ^ bus.in_imm[11];
    assign w_b_bad = bus.in_imm[0];
`else
    assign w_i_bad = 1'b0;
    assign w_b_bad = 1'b0;
`endif

    always_comb begin
        w_word      = '0;
        w_legal     = 1'b1;
        w_range_bad = 1'b0;
        unique case (w_fmt)
            FMT_R: begin
                w_word = enc_r(bus.in_funct7, bus.in_rs2,
                               bus.in_rs1, bus.in_funct3,
                               bus.in_rd);
            end
            FMT_LOAD: begin
                w_word = enc_i(bus.in_imm[11:0], bus.in_rs1,
                               bus.in_funct3, bus.in_rd,
                               OP_LOAD);
                w_range_bad = w_i_bad;
            end
            FMT_STORE: begin
                w_word = enc_s(bus.in_imm[11:0], bus.in_rs2,
                               bus.in_rs1, bus.in_funct3);
                w_range_bad = w_i_bad;
            end
            FMT_BRANCH: begin
                w_word = enc_b(bus.in_imm[12:1], bus.in_rs2,
                               bus.in_rs1, bus.in_funct3);
                w_range_bad = w_b_bad;
            end
            FMT_OPIMM: begin
                w_word = enc_i(bus.in_imm[11:0], bus.in_rs1,
                               bus.in_funct3, bus.in_rd,
                               OP_IMM);
                w_range_bad = w_i_bad;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // in_ready comes only from the registered count; a pop never frees a slot early.
    assign w_accept = bus.in_valid & ~w_full;
    assign w_push   = w_accept & w_legal & ~w_range_bad;
    assign w_pop    = bus.out_ready & ~w_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_word),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Requests taken in a flush cycle are discarded, so they raise no error either.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            r_err_illegal <= w_accept & ~w_legal;
            r_err_range   <= w_accept & w_legal & w_range_bad;
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.out_valid   = ~w_empty;
    assign bus.out_instr   = w_dout;
    assign bus.count       = w_count;
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_range   = r_err_range;
endmodule

// File: tb/tb_instr_encoder_q.sv
// tb_instr_encoder_q: directed requests with hand-computed words.
// Stimulus queues expected words; a negedge monitor pops and compares.
module tb_instr_encoder_q;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_encoder_q_if #(.CNT_W(3)) ifc();

    instr_encoder_q #(
        .DEPTH (4),
        .CNT_W (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (ifc.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %h want none",
                         ifc.out_instr);
            end else begin
                chk("fifo_out", ifc.out_instr, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [12:0] imm);
        ifc.in_fmt    = f;
        ifc.in_rd     = rd;
        ifc.in_rs1    = rs1;
        ifc.in_rs2    = rs2;
        ifc.in_funct3 = f3;
        ifc.in_funct7 = f7;
        ifc.in_imm    = imm;
    endtask

    task automatic send(input logic [2:0] f, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm, input logic [31:0] w,
                        input bit enq);
        bit acc = 1'b0;
        drive(f, rd, rs1, rs2, f3, f7, imm);
        ifc.in_valid = 1'b1;
        if (enq) exp_q.push_back(w);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.count == 3'd0) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got count=%0d want 0",
                     ifc.count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_count", 32'(ifc.count), 32'd0);
        chk("rst_out_instr", ifc.out_instr, 32'h0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_err_illegal", 32'(ifc.err_illegal), 32'd0);
        chk("rst_err_range", 32'(ifc.err_range), 32'd0);
        @(posedge clk);
        #1;

        // First word: one-cycle latency into an empty queue
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5,
             32'h00500093, 1'b1);
        @(negedge clk);
        chk("lat_out_valid", 32'(ifc.out_valid), 32'd1);
        chk("lat_out_instr", ifc.out_instr, 32'h00500093);
        chk("lat_count", 32'(ifc.count), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // All formats streaming with the consumer ready
        ifc.out_ready = 1'b1;
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0,
             32'h002081B3, 1'b1);
        send(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8,
             32'h00812283, 1'b1);
        send(3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12,
             32'h00512623, 1'b1);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8,
             32'hFE208CE3, 1'b1);
        send(3'd4, 5'd1, 5'd1, 5'd0, 3'd5, 7'd0, 13'h0403,
             32'h4030D093, 1'b1);
`ifdef ENC_RANGE_CHECK_EN
        send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd3,
             32'h0, 1'b0);
        @(negedge clk);
        chk("range_err_range", 32'(ifc.err_range), 32'd1);
        chk("range_err_illegal", 32'(ifc.err_illegal), 32'd0);
        @(posedge clk);
        #1;
`else
        send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd3,
             32'h00000163, 1'b1);
        @(negedge clk);
        chk("trunc_err_range", 32'(ifc.err_range), 32'd0);
        @(posedge clk);
        #1;
`endif
        drain();

        // Illegal format is taken but not queued
        send(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd1,
             32'h00100113, 1'b1);
        send(3'd6, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 13'h1FFF,
             32'h0, 1'b0);
        @(negedge clk);
        chk("ill_err_illegal", 32'(ifc.err_illegal), 32'd1);
        chk("ill_err_range", 32'(ifc.err_range), 32'd0);
        chk("ill_count", 32'(ifc.count), 32'd1);
        @(negedge clk);
        chk("ill_pulse_end", 32'(ifc.err_illegal), 32'd0);
        @(posedge clk);
        #1;

        // Fill to DEPTH, then pop while a push is pending
        send(3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd2,
             32'h00200193, 1'b1);
        send(3'd4, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 13'd3,
             32'h00300213, 1'b1);
        send(3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 13'd4,
             32'h00400293, 1'b1);
        @(negedge clk);
        chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("full_count", 32'(ifc.count), 32'd4);
        @(posedge clk);
        #1;
        drive(3'd4, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
        exp_q.push_back(32'h00500313);
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("full_refuse", 32'(ifc.in_ready), 32'd0);
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_ready", 32'(ifc.in_ready), 32'd1);
        chk("after_pop_count", 32'(ifc.count), 32'd3);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("refill_count", 32'(ifc.count), 32'd4);
        @(posedge clk);
        #1;
        drain();

        // Flush beats a same-cycle push
        send(3'd4, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 13'd6,
             32'h00600393, 1'b1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0,
             32'h002081B3, 1'b1);
        send(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8,
             32'h00812283, 1'b1);
        drive(3'd4, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 13'd7);
        ifc.in_valid = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        ifc.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_count", 32'(ifc.count), 32'd0);
        chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("flush_out_instr", ifc.out_instr, 32'h0);
        chk("flush_in_ready", 32'(ifc.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12,
             32'h00512623, 1'b1);
        drain();

        // Reset mid-stream discards everything
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5,
             32'h00500093, 1'b1);
        send(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd1,
             32'h00100113, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_count", 32'(ifc.count), 32'd0);
        chk("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("mid_rst_out_instr", ifc.out_instr, 32'h0);
        chk("queue_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
